dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: fixed-latency word store with a busy/resp_valid handshake.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault accesses whose addr[1:0] is non-zero.
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              resp_valid,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              accept;
  logic              do_access;
  logic              oor;
  logic              misalign;
  logic              fault;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem [DEPTH];

  // Request is frozen at acceptance; everything downstream reads req_q only.
  assign idx = req_q.addr[IDX_W+1:2];
  assign oor = (req_q.addr >> (IDX_W + 2)) != '0;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = |req_q.addr[1:0];
`else
  logic unused_low_bits;
  assign unused_low_bits = ^req_q.addr[1:0];
  assign misalign        = 1'b0;
`endif

  assign fault = oor | misalign;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // req_valid is deliberately ignored here; requester holds it while busy.
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= '{we: we, addr: addr, wdata: wdata};
      // err_q is only ever set on the access edge, so it lives exactly one RESP cycle.
      err_q <= do_access & fault;
      if (do_access) begin
        if (fault)          rdata_q <= '0;
        else if (!req_q.we) rdata_q <= mem[idx];
      end
    end
  end

  // Store has no reset; rst still blocks the commit so an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!rst && do_access && req_q.we && !fault) mem[idx] <= req_q.wdata;
  end

  // busy covers the whole WAIT phase, i.e. LATENCY cycles per access.
  assign busy       = (state_q == WAIT);
  assign resp_valid = (state_q == RESP);
  assign err        = err_q & resp_valid;
  assign rdata      = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int IDX_W   = $clog2(DEPTH);
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              resp_valid;
  logic              busy;
  logic              err;

  int n_chk = 0;
  int n_err = 0;

  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] last_rdata;

  dmem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .resp_valid(resp_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_fault(input logic [ADDR_W-1:0] a);
    return (a >= ADDR_W'(DEPTH * 4)) || (MIS && (a[1:0] != 2'b00));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_resp", resp_valid, 1'b0);
    end
  endtask

  // Issue one access, present it for one edge, scramble the inputs during WAIT,
  // and check the response against the model. Returns with the DUT in RESP.
  task automatic send(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] exp_rdata;
    logic [IDX_W-1:0]  i_w;
    bit                f;
    bit                early;
    int                bcnt;
    req_valid = 1'b1; we = w; addr = a; wdata = d;
    tick();
    f   = is_fault(a);
    i_w = a[IDX_W+1:2];
    if (f)      exp_rdata = '0;
    else if (w) exp_rdata = last_rdata;
    else        exp_rdata = model[i_w];
    if (!f && w) model[i_w] = d;
    bcnt  = 0;
    early = 1'b0;
    for (int k = 0; k < LATENCY; k++) begin
      if (busy) bcnt++;
      if (resp_valid || err) early = 1'b1;
      req_valid = 1'($urandom); we = 1'($urandom); addr = $urandom; wdata = $urandom;
      tick();
    end
    req_valid = 1'b0;
    chk("busy_cycles", bcnt, LATENCY);
    chk("early_resp", early, 1'b0);
    chk("resp_valid", resp_valid, 1'b1);
    chk("busy_in_resp", busy, 1'b0);
    chk("err", err, f);
    chk("rdata", rdata, exp_rdata);
    last_rdata = exp_rdata;
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] pre;
    int r;
    rst = 1'b1; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    last_rdata = '0;
    repeat (3) tick();
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, '0);
    rst = 1'b0;
    idle(1);

    // Give every word a known value, back-to-back.
    for (int i = 0; i < DEPTH; i++) send(1'b1, ADDR_W'(i * 4), $urandom);
    idle(2);

    // Basic write/read of 0x10.
    send(1'b1, 32'h10, 32'hDEADBEEF);
    idle(1);
    send(1'b0, 32'h10, '0);
    chk("deadbeef", rdata, 32'hDEADBEEF);
    idle(1);

    // Back-to-back write then read of address 0.
    send(1'b1, 32'h0, 32'h1);
    send(1'b0, 32'h0, '0);
    chk("b2b_read", rdata, 32'h1);
    idle(1);

    // Out of range read and write.
    send(1'b0, 32'h400, '0);
    chk("oor_err", err, 1'b1);
    chk("oor_rdata", rdata, '0);
    send(1'b1, 32'h400, 32'h12345678);
    send(1'b0, 32'h0, '0);
    chk("oor_word0", rdata, 32'h1);
    idle(1);

    // Misaligned write to 0x22 (word 8).
    send(1'b1, 32'h22, 32'h55);
    chk("mis_err", err, MIS);
    send(1'b0, 32'h20, '0);
    idle(1);

    // Reset while a write to 0x8 is waiting.
    pre = model[2];
    req_valid = 1'b1; we = 1'b1; addr = 32'h8; wdata = 32'hAA;
    tick();
    req_valid = 1'b0;
    chk("abort_busy_pre", busy, 1'b1);
    rst = 1'b1;
    tick();
    chk("abort_resp_valid", resp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_err", err, 1'b0);
    chk("abort_rdata", rdata, '0);
    rst = 1'b0;
    last_rdata = '0;
    idle(LATENCY + 1);
    send(1'b0, 32'h8, '0);
    chk("abort_word2", rdata, pre);
    idle(1);

    // Random mix of reads/writes, faults and idle gaps.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        a = $urandom;
        if (a < 32'h400) a = a | 32'h400;
      end else if (r == 1) begin
        a = ADDR_W'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      end else begin
        a = ADDR_W'($urandom_range(0, DEPTH - 1) * 4);
      end
      send(1'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    // Final sweep: every word must match the model.
    for (int i = 0; i < DEPTH; i++) send(1'b0, ADDR_W'(i * 4), '0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
